// File: rtl/compressor_pkg.sv
// rtl/compressor_pkg.sv - shared constants and FSM state type for the compressor front end
//
// Purpose: default operand geometry, counter widths and the sequencer
//          state encoding shared by compressor and compressor_sequencer.
// Ports:   none (package).

package compressor_pkg;

   localparam int DEF_N_OPS     = 20;  // compressor operand slots
   localparam int DEF_WIDTH     = 20;  // bits per operand
   localparam int DEF_OUT_WIDTH = 26;  // compressor sum width
   localparam int CNT_W         = 5;   // op_count width (0..N_OPS)
   localparam int SETTLE_W      = 4;   // settle counter width (LATENCY 0..15)

   typedef enum logic [1:0] {
      LOAD   = 2'd0,
      SETTLE = 2'd1,
      DONE   = 2'd2
   } seq_state_t;

endpackage

// File: rtl/compressor.sv
// rtl/compressor.sv - 20-operand unsigned compressor (sum of all src ports)
//
// Purpose: adds twenty unsigned DEF_WIDTH-bit operands and presents the
//          DEF_OUT_WIDTH-bit sum as individual result bits.
// Ports:   src0..src19 in  DEF_WIDTH : operands
//          dst0..dst25 out 1         : sum bits, dst0 = LSB

module compressor
   import compressor_pkg::*;
(
   input  logic [DEF_WIDTH-1:0] src0,
   input  logic [DEF_WIDTH-1:0] src1,
   input  logic [DEF_WIDTH-1:0] src2,
   input  logic [DEF_WIDTH-1:0] src3,
   input  logic [DEF_WIDTH-1:0] src4,
   input  logic [DEF_WIDTH-1:0] src5,
   input  logic [DEF_WIDTH-1:0] src6,
   input  logic [DEF_WIDTH-1:0] src7,
   input  logic [DEF_WIDTH-1:0] src8,
   input  logic [DEF_WIDTH-1:0] src9,
   input  logic [DEF_WIDTH-1:0] src10,
   input  logic [DEF_WIDTH-1:0] src11,
   input  logic [DEF_WIDTH-1:0] src12,
   input  logic [DEF_WIDTH-1:0] src13,
   input  logic [DEF_WIDTH-1:0] src14,
   input  logic [DEF_WIDTH-1:0] src15,
   input  logic [DEF_WIDTH-1:0] src16,
   input  logic [DEF_WIDTH-1:0] src17,
   input  logic [DEF_WIDTH-1:0] src18,
   input  logic [DEF_WIDTH-1:0] src19,
   output logic                 dst0,
   output logic                 dst1,
   output logic                 dst2,
   output logic                 dst3,
   output logic                 dst4,
   output logic                 dst5,
   output logic                 dst6,
   output logic                 dst7,
   output logic                 dst8,
   output logic                 dst9,
   output logic                 dst10,
   output logic                 dst11,
   output logic                 dst12,
   output logic                 dst13,
   output logic                 dst14,
   output logic                 dst15,
   output logic                 dst16,
   output logic                 dst17,
   output logic                 dst18,
   output logic                 dst19,
   output logic                 dst20,
   output logic                 dst21,
   output logic                 dst22,
   output logic                 dst23,
   output logic                 dst24,
   output logic                 dst25
);

   logic [DEF_OUT_WIDTH-1:0] sum;

   // Operands are zero-extended to the full result width before adding so
   // no intermediate carry is lost.
   assign sum = DEF_OUT_WIDTH'(src0)  + DEF_OUT_WIDTH'(src1)  + DEF_OUT_WIDTH'(src2)
              + DEF_OUT_WIDTH'(src3)  + DEF_OUT_WIDTH'(src4)  + DEF_OUT_WIDTH'(src5)
              + DEF_OUT_WIDTH'(src6)  + DEF_OUT_WIDTH'(src7)  + DEF_OUT_WIDTH'(src8)
              + DEF_OUT_WIDTH'(src9)  + DEF_OUT_WIDTH'(src10) + DEF_OUT_WIDTH'(src11)
              + DEF_OUT_WIDTH'(src12) + DEF_OUT_WIDTH'(src13) + DEF_OUT_WIDTH'(src14)
              + DEF_OUT_WIDTH'(src15) + DEF_OUT_WIDTH'(src16) + DEF_OUT_WIDTH'(src17)
              + DEF_OUT_WIDTH'(src18) + DEF_OUT_WIDTH'(src19);

   assign {dst25, dst24, dst23, dst22, dst21, dst20, dst19, dst18, dst17, dst16,
           dst15, dst14, dst13, dst12, dst11, dst10, dst9,  dst8,  dst7,  dst6,
           dst5,  dst4,  dst3,  dst2,  dst1,  dst0} = sum;

endmodule

// File: rtl/compressor_sequencer.sv
// rtl/compressor_sequencer.sv - framed valid/ready loader and result capture for the compressor
//
// Purpose: accepts up to N_OPS operand beats per frame, loads them into the
//          compressor operand registers (unused slots stay zero), waits
//          LATENCY+1 edges, captures the sum and offers it on a result port.
// Ports:   clk        in  1         : clock, rising edge
//          rst_n      in  1         : asynchronous active-low reset
//          flush      in  1         : synchronous abort of frame/result
//          in_valid   in  1         : operand beat valid
//          in_ready   out 1         : operand beat accepted (LOAD)
//          in_data    in  WIDTH     : operand value
//          in_last    in  1         : final operand of frame
//          out_valid  out 1         : out_sum valid (DONE)
//          out_ready  in  1         : consumer accepts result
//          out_sum    out OUT_WIDTH : captured compressor sum
//          op_count   out 5         : operands accepted in current frame
//          busy       out 1         : high unless idle in LOAD with no operands

module compressor_sequencer
   import compressor_pkg::*;
#(
   parameter int N_OPS     = DEF_N_OPS,
   parameter int WIDTH     = DEF_WIDTH,
   parameter int OUT_WIDTH = DEF_OUT_WIDTH,
   parameter int LATENCY   = 0
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 flush,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [WIDTH-1:0]     in_data,
   input  logic                 in_last,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [OUT_WIDTH-1:0] out_sum,
   output logic [CNT_W-1:0]     op_count,
   output logic                 busy
);

   seq_state_t             state;
   logic [SETTLE_W-1:0]    settle_cnt;
   logic [WIDTH-1:0]       ops [N_OPS];
   logic [OUT_WIDTH-1:0]   comp_sum;

   assign busy = !((state == LOAD) && (op_count == '0));

   compressor u_compressor (
      .src0  (ops[0]),   .src1  (ops[1]),   .src2  (ops[2]),   .src3  (ops[3]),
      .src4  (ops[4]),   .src5  (ops[5]),   .src6  (ops[6]),   .src7  (ops[7]),
      .src8  (ops[8]),   .src9  (ops[9]),   .src10 (ops[10]),  .src11 (ops[11]),
      .src12 (ops[12]),  .src13 (ops[13]),  .src14 (ops[14]),  .src15 (ops[15]),
      .src16 (ops[16]),  .src17 (ops[17]),  .src18 (ops[18]),  .src19 (ops[19]),
      .dst0  (comp_sum[0]),  .dst1  (comp_sum[1]),  .dst2  (comp_sum[2]),
      .dst3  (comp_sum[3]),  .dst4  (comp_sum[4]),  .dst5  (comp_sum[5]),
      .dst6  (comp_sum[6]),  .dst7  (comp_sum[7]),  .dst8  (comp_sum[8]),
      .dst9  (comp_sum[9]),  .dst10 (comp_sum[10]), .dst11 (comp_sum[11]),
      .dst12 (comp_sum[12]), .dst13 (comp_sum[13]), .dst14 (comp_sum[14]),
      .dst15 (comp_sum[15]), .dst16 (comp_sum[16]), .dst17 (comp_sum[17]),
      .dst18 (comp_sum[18]), .dst19 (comp_sum[19]), .dst20 (comp_sum[20]),
      .dst21 (comp_sum[21]), .dst22 (comp_sum[22]), .dst23 (comp_sum[23]),
      .dst24 (comp_sum[24]), .dst25 (comp_sum[25])
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= LOAD;
         in_ready   <= 1'b1;
         out_valid  <= 1'b0;
         out_sum    <= '0;
         op_count   <= '0;
         settle_cnt <= '0;
         for (int i = 0; i < N_OPS; i++) ops[i] <= '0;
      end else if (flush) begin
         // out_sum is deliberately kept; only the valid qualifier drops.
         state      <= LOAD;
         in_ready   <= 1'b1;
         out_valid  <= 1'b0;
         op_count   <= '0;
         settle_cnt <= '0;
         for (int i = 0; i < N_OPS; i++) ops[i] <= '0;
      end else begin
         case (state)
            LOAD: begin
               if (in_valid) begin
                  for (int i = 0; i < N_OPS; i++) begin
                     if (op_count == CNT_W'(i)) ops[i] <= in_data;
                  end
                  op_count <= op_count + 1'b1;
                  // A full frame ends itself; in_last on the final slot adds nothing.
                  if (in_last || (op_count == CNT_W'(N_OPS - 1))) begin
                     state      <= SETTLE;
                     in_ready   <= 1'b0;
                     settle_cnt <= '0;
                  end
               end
            end
            SETTLE: begin
               if (settle_cnt == SETTLE_W'(LATENCY)) begin
                  out_sum   <= comp_sum;
                  out_valid <= 1'b1;
                  state     <= DONE;
               end else begin
                  settle_cnt <= settle_cnt + 1'b1;
               end
            end
            DONE: begin
               if (out_ready) begin
                  state     <= LOAD;
                  in_ready  <= 1'b1;
                  out_valid <= 1'b0;
                  op_count  <= '0;
                  for (int i = 0; i < N_OPS; i++) ops[i] <= '0;
               end
            end
            default: begin
               state     <= LOAD;
               in_ready  <= 1'b1;
               out_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_compressor_sequencer.sv
// tb/tb_compressor_sequencer.sv - directed self-checking bench for compressor_sequencer

module tb_compressor_sequencer;
   import compressor_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        flush;
   logic        in_valid;
   logic        in_ready;
   logic [19:0] in_data;
   logic        in_last;
   logic        out_valid;
   logic        out_ready;
   logic [25:0] out_sum;
   logic [4:0]  op_count;
   logic        busy;

   int checks = 0;
   int fails  = 0;

   compressor_sequencer #(
      .N_OPS(20), .WIDTH(20), .OUT_WIDTH(26), .LATENCY(0)
   ) dut (
      .clk(clk), .rst_n(rst_n), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
      .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
      .op_count(op_count), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   task automatic beat(input logic [19:0] d, input logic l);
      in_valid = 1'b1;
      in_data  = d;
      in_last  = l;
      tick();
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   task automatic handshake;
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
   endtask

   logic [19:0] vals [4];
   logic [25:0] ref_sum;
   int          gaps;

   initial begin
      rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = '0;
      in_last = 1'b0; out_ready = 1'b0;
      tick(); tick();
      chk("rst_in_ready",  in_ready,  1);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_sum",   out_sum,   0);
      chk("rst_op_count",  op_count,  0);
      chk("rst_busy",      busy,      0);
      rst_n = 1'b1;
      tick();

      // Full frame of maximum operands
      for (int i = 0; i < 20; i++) begin
         beat(20'hFFFFF, i == 19);
         if (i == 0) begin
            chk("t1_op_count_1", op_count, 1);
            chk("t1_busy",       busy,     1);
         end
      end
      chk("t1_in_ready_low",   in_ready,  0);
      chk("t1_no_valid_yet",   out_valid, 0);
      chk("t1_op_count_20",    op_count,  20);
      tick();
      chk("t1_out_valid",      out_valid, 1);
      chk("t1_out_sum",        out_sum,   32'h13FFFEC);
      handshake();
      chk("t1_post_valid",     out_valid, 0);
      chk("t1_post_in_ready",  in_ready,  1);
      chk("t1_post_op_count",  op_count,  0);
      chk("t1_post_busy",      busy,      0);

      // {1,2,3} with back-pressure, then a 1-beat frame
      beat(20'd1, 1'b0);
      beat(20'd2, 1'b0);
      beat(20'd3, 1'b1);
      chk("t2_op_count_settle", op_count, 3);
      chk("t2_busy_settle",     busy,     1);
      tick();
      chk("t2_out_valid",       out_valid, 1);
      chk("t2_out_sum",         out_sum,   6);
      in_valid = 1'b1; in_data = 20'd99; in_last = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("t3_hold_sum",      out_sum,   6);
         chk("t3_hold_in_ready", in_ready,  0);
         chk("t3_hold_valid",    out_valid, 1);
      end
      in_valid = 1'b0; in_last = 1'b0;
      handshake();
      beat(20'd5, 1'b1);
      tick();
      chk("t3_second_valid", out_valid, 1);
      chk("t3_second_sum",   out_sum,   5);
      handshake();

      // Flush aborts a partial frame
      for (int i = 0; i < 4; i++) beat(20'd7, 1'b0);
      chk("t4_op_count_4", op_count, 4);
      flush = 1'b1; tick(); flush = 1'b0;
      chk("t4_flush_op_count", op_count,  0);
      chk("t4_flush_in_ready", in_ready,  1);
      chk("t4_flush_busy",     busy,      0);
      tick(); tick(); tick();
      chk("t4_no_result",      out_valid, 0);
      beat(20'd1, 1'b0);
      beat(20'd1, 1'b1);
      tick();
      chk("t4_out_valid",      out_valid, 1);
      chk("t4_out_sum",        out_sum,   2);
      flush = 1'b1; tick(); flush = 1'b0;
      chk("t4_done_flush_valid", out_valid, 0);
      chk("t4_done_flush_sum",   out_sum,   2);
      chk("t4_done_flush_ready", in_ready,  1);

      // Asynchronous reset mid-SETTLE
      beat(20'd9, 1'b1);
      chk("t5_settle_op_count", op_count, 1);
      #1 rst_n = 1'b0;
      #1;
      chk("t5_rst_out_valid", out_valid, 0);
      chk("t5_rst_out_sum",   out_sum,   0);
      chk("t5_rst_op_count",  op_count,  0);
      chk("t5_rst_in_ready",  in_ready,  1);
      tick(); tick();
      rst_n = 1'b1;
      tick();
      beat(20'd4, 1'b0);
      beat(20'd4, 1'b1);
      tick();
      chk("t5_out_valid", out_valid, 1);
      chk("t5_out_sum",   out_sum,   8);
      handshake();

      // Random in_valid gaps with out_ready held high throughout
      vals[0] = 20'd3; vals[1] = 20'h00100; vals[2] = 20'd10; vals[3] = 20'hABCDE;
      ref_sum = '0;
      out_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         gaps = int'($urandom_range(0, 3));
         for (int g = 0; g < gaps; g++) begin
            tick();
            chk("t6_gap_op_count", op_count, 32'(k));
         end
         beat(vals[k], k == 3);
         ref_sum = ref_sum + 26'(vals[k]);
         chk("t6_beat_op_count", op_count, 32'(k + 1));
      end
      chk("t6_settle_no_valid", out_valid, 0);
      tick();
      chk("t6_out_valid", out_valid, 1);
      chk("t6_out_sum",   out_sum,   32'(ref_sum));
      tick();
      chk("t6_consumed_valid", out_valid, 0);
      chk("t6_consumed_ready", in_ready,  1);
      out_ready = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule

// File: doc/compressor_sequencer.md
# compressor_sequencer

Front-end controller for the multi-operand `compressor` datapath. It collects up to `N_OPS` operands over a valid/ready stream and loads them into the compressor's operand registers, zeroing any unused slots. It then waits a fixed settle time, captures the compressor sum and returns it on a valid/ready result port. It replaces the free-running shift-register loader for system use and gives the compressor a framed, back-pressured interface.

## Interface
- `N_OPS`, 20, number of compressor operands (slots)
- `WIDTH`, 20, bits per operand
- `OUT_WIDTH`, 26, width of compressor sum (`dst0..dst25` concatenated, `dst0` = LSB)
- `LATENCY`, 0, extra settle cycles allowed for the compressor before capture (0..15)

- `clk` in 1: single clock, all state on rising edge
- `rst_n` in 1: asynchronous, active-low reset
- `flush` in 1: synchronous abort of the current frame/result
- `in_valid` in 1: operand beat valid
- `in_ready` out 1: block accepts operand beat
- `in_data` in WIDTH: operand value
- `in_last` in 1: final operand of frame (qualified by `in_valid`)
- `out_valid` out 1: `out_sum` valid
- `out_ready` in 1: consumer accepts result
- `out_sum` out OUT_WIDTH: captured compressor sum
- `op_count` out 5: operands accepted in current frame (0..N_OPS)
- `busy` out 1: high unless in LOAD with `op_count` = 0

## Operation
- FSM states:
  - LOAD: `in_ready`=1
  - SETTLE
  - DONE: `out_valid`=1
- Decoded outputs (`in_ready`, `out_valid`) come from state only; no combinational path from inputs.
- LOAD, on handshake (`in_valid & in_ready`):
  - write `in_data` into operand slot `op_count`, then increment `op_count`.
  - If `in_last` or `op_count` = N_OPS-1 → SETTLE, settle counter = 0.
  - `in_last` on slot N_OPS-1 is redundant and has no extra effect.
- Unused slots hold 0: all operand registers are cleared on reset, on `flush`, and on the result handshake.
- SETTLE, each edge:
  - if counter = LATENCY: capture the compressor output into `out_sum` and go to DONE.
  - otherwise increment the counter.
- DONE: `out_sum` held stable while `out_valid` is high. On `out_ready` → LOAD, `op_count` = 0, operands cleared.
- `in_valid` is ignored outside LOAD; `out_ready` is ignored outside DONE.
- `flush` has priority over every handshake in the same cycle:
  - next state LOAD, `op_count` 0, operands 0, settle counter 0.
  - `out_sum` is retained, but `out_valid` drops.
- Arithmetic: the compressor sums unsigned operands. `out_sum` is the full OUT_WIDTH result; the 20×20-bit maximum sum fits in 25 bits, so bit 25 is always 0.
- There is no empty frame; every frame has at least one beat.

## Timing
- Reset values:
  - state LOAD, so `in_ready`=1 (bench must hold `in_valid` low during reset)
  - `out_valid` 0, `out_sum` 0, `op_count` 0, `busy` 0
  - all operands 0, settle counter 0
- Reset takes effect immediately (asynchronously) in any state, including mid-SETTLE and DONE.
- `out_valid` rises exactly LATENCY+1 edges after the edge that accepts the final beat.
- Minimum frame period: beats + LATENCY + 2 cycles (result handshake costs one cycle in DONE).
- No overlap: the next frame's first beat is accepted at the earliest on the edge after the result handshake.

## Structure
- Shared package `compressor_pkg`:
  - N_OPS/WIDTH/OUT_WIDTH defaults
  - FSM state enum `seq_state_t` (LOAD, SETTLE, DONE)
  - count width constant
- One sub-module: the existing `compressor`, instantiated unmodified.
  - Operand registers `src0..src{N_OPS-1}` drive its `src` ports.
  - Its `dst` bits are concatenated into the capture register.
- Settle counter is 4 bits.

## Test plan
- 20 beats of 20'hFFFFF, `in_last` on beat 20 → `out_sum` = 26'h13FFFEC; `out_valid` LATENCY+1 edges after last accept; `in_ready` low from that edge.
- 3 beats 1, 2, 3 with `in_last` on beat 3 → `out_sum` = 6; `op_count` reads 3 in SETTLE.
- Frame {1,2,3} with `out_ready` low for 5 cycles, then a 1-beat frame {5,last} → `out_sum` stable at 6 for all 5 cycles with `in_ready` 0; second result = 5 (stale slots cleared).
- 4 beats of 7, then `flush`, then {1,1,last} → `out_valid` never rises for the aborted frame; result = 2.
- `rst_n` low mid-SETTLE of frame {9,last} → `out_valid` 0, `out_sum` 0, `op_count` 0 immediately; after release, {4,4,last} → 8.
- Beats with random `in_valid` gaps and `out_ready` asserted before DONE → `op_count` advances only on handshakes; early `out_ready` is ignored; result matches the reference sum.
